matrix_addsub_axis_stream: RTL
==============================

Name: matrix_addsub_axis_stream

Overview:
- Parametrised streaming successor to the fixed-size matrix-add AXI-Stream wrapper.
- Takes element-wise A±B matrices as a stream of beats. Each beat carries LANES (A,B) element pairs, so full matrices are never buffered.
- Full-throughput 2-stage pipeline with backpressure, per-frame add/subtract mode, generated output TLAST, and input-frame checking.
- Sits between the DMA/AXIS fabric and downstream linear-algebra layers.

Parameters:
- DATA_W, 16, signed element width of A and B.
- ROWS, 10, matrix rows.
- COLS, 12, matrix columns.
- LANES, 12, elements per beat; ROWS*COLS must be a multiple of LANES, otherwise elaboration error.
- FCNT_W, 16, width of the completed-frame counter.
- Derived: BEATS = ROWS*COLS/LANES; SUM_W = DATA_W+1 (DATA_W when MATADD_SAT_EN).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  2*LANES*DATA_W  A lane i at [i*DATA_W +: DATA_W]; B lane i at [(LANES+i)*DATA_W +: DATA_W].
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat accepted when high with tvalid.
- s_axis_tlast  in  1  sender's end-of-matrix marker; checked only.
- op_sub  in  1  0=A+B, 1=A-B; sampled on first beat of each frame.
- m_axis_tdata  out  LANES*SUM_W  result lane i at [i*SUM_W +: SUM_W], signed.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  high on beat BEATS-1 of each frame.
- frame_err  out  1  sticky framing error.
- frame_cnt  out  FCNT_W  completed output frames, wraps.

Behaviour:
- Reset (async assert, sync deassert inside block):
  - All valids 0; m_axis_tdata 0; m_axis_tlast 0; frame_err 0; frame_cnt 0; beat counter 0; latched op 0.
  - s_axis_tready is 0 while aresetn low, 1 from the first cycle after release.
  - Reset mid-frame discards all in-flight beats; no partial frame is emitted.
- Pipeline:
  - Stage 1 registers A, B, op and last flag. Stage 2 registers the result.
  - Latency: input accept at cycle t gives m_axis_tvalid at t+2 if downstream is ready.
  - Stage k advances when !valid_k || ready_{k+1}. s_axis_tready = !v1 || !v2 || m_axis_tready (combinational from m_axis_tready).
  - Throughput is 1 beat/cycle with no bubbles under continuous ready.
  - m_axis_tdata and m_axis_tlast hold stable while tvalid && !tready.
- Arithmetic:
  - Sign-extend both operands to SUM_W.
  - Compute A+B, or A+~B+1 when op=1.
  - No overflow is possible at SUM_W = DATA_W+1.
- Beat counter (0..BEATS-1):
  - Increments on input handshake and wraps to 0 after BEATS-1.
  - On counter==0, op_sub is latched and applies to the entire frame; changes mid-frame are ignored.
  - Output tlast flag = (counter==BEATS-1), carried through the pipeline.
- Framing check on input handshake:
  - tlast=1 with counter<BEATS-1 (early): set frame_err; the beat is emitted with m_axis_tlast=1; counter resyncs to 0.
  - tlast=0 with counter==BEATS-1 (missing): set frame_err; counter still wraps; m_axis_tlast=1 as generated.
  - frame_err clears only on reset.
- frame_cnt increments on output handshake with m_axis_tlast=1 and wraps at 2^FCNT_W.
- BEATS=1 is legal: every beat is last, and op_sub is sampled every beat.

Optional Feature:
- Macro MATADD_SAT_EN.
- When defined: SUM_W = DATA_W. Results are clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1], computed via a 1-bit-wider internal sum.
- When undefined: full-precision DATA_W+1 output, no clamping.

Decomposition:
- Package matadd_pkg: SUM_W/BEATS derivation functions, lane-slicing helper functions, op encoding constants (OP_ADD=0, OP_SUB=1).
- One natural sub-module: matadd_lane_alu, a combinational single-lane add/sub with optional saturation, instantiated LANES times via generate.
- Pipeline registers and counter stay in the top level.

Test Plan:
- Defaults, 10 beats, all A=3, B=4, op_sub=0, m_axis_tready=1 -> 10 outputs all lanes 7, tlast only on beat 10, first output 2 cycles after first accept, frame_cnt=1.
- op_sub=1 on beat 0, toggled to 0 on beat 5; A=-32768, B=1 -> all 10 beats give -32769 (17-bit 0x17FFF); frame_err=0.
- m_axis_tready random 50%, 3 back-to-back frames of incrementing data -> output bit-exact vs model, no loss or duplication, data stable under stall, frame_cnt=3.
- s_axis_tlast asserted on beat 4 -> frame_err=1, output beat 4 has tlast=1, next input beat starts a new frame with counter 0.
- aresetn pulsed low mid-frame with 2 beats in flight -> m_axis_tvalid=0 immediately, frame_cnt=0, next frame processed normally.
- MATADD_SAT_EN defined, A=32767, B=1 add -> 32767; A=-32768, B=1 sub -> -32768.

Source files
------------

// File: rtl/matadd_pkg.sv
// Shared widths, lane offsets and op encodings for the streaming matrix add/sub block.
// MATADD_SAT_EN narrows the result lanes to DATA_W with clamping.
package matadd_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int sum_w(input int data_w);
`ifdef MATADD_SAT_EN
    return data_w;
`else
    return data_w + 1;
`endif
  endfunction

  function automatic int beats(input int rows, input int cols, input int lanes);
    return (rows * cols) / lanes;
  endfunction

  // A operands occupy the low half of tdata, B operands the high half.
  function automatic int a_lsb(input int lane, input int data_w);
    return lane * data_w;
  endfunction

  function automatic int b_lsb(input int lane, input int lanes, input int data_w);
    return (lanes + lane) * data_w;
  endfunction

endpackage

// File: rtl/matadd_lane_alu.sv
// Combinational single-lane A+B / A-B on a sign-extended DATA_W+1 sum.
// With MATADD_SAT_EN the sum is clamped back into the signed DATA_W range.
module matadd_lane_alu
  import matadd_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int SUM_W  = 17
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              op,
  output logic [SUM_W-1:0]  y
);
  localparam int EXT_W = DATA_W + 1;

  logic [EXT_W-1:0] a_ext;
  logic [EXT_W-1:0] b_ext;
  logic [EXT_W-1:0] b_opnd;
  logic [EXT_W-1:0] sum;

  assign a_ext  = {a[DATA_W-1], a};
  assign b_ext  = {b[DATA_W-1], b};
  assign b_opnd = (op == OP_SUB) ? ~b_ext : b_ext;
  assign sum    = a_ext + b_opnd + {{(EXT_W-1){1'b0}}, (op == OP_SUB)};

`ifdef MATADD_SAT_EN
  // Overflow shows up as disagreement between the guard bit and the DATA_W sign bit.
  always_comb begin
    y = sum[DATA_W-1:0];
    if (sum[EXT_W-1] != sum[DATA_W-1]) begin
      y = sum[EXT_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  assign y = sum;
`endif

endmodule

// File: rtl/matrix_addsub_axis_stream.sv
// AXI-Stream element-wise A+/-B, LANES pairs per beat; 2-cycle latency, 1 beat/cycle.
// s_axis_tready = !v1 || !v2 || m_axis_tready; MATADD_SAT_EN selects clamped DATA_W output.
module matrix_addsub_axis_stream
  import matadd_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int ROWS   = 10,
  parameter  int COLS   = 12,
  parameter  int LANES  = 12,
  parameter  int FCNT_W = 16,
  localparam int SUM_W  = sum_w(DATA_W),
  localparam int IN_W   = 2 * LANES * DATA_W,
  localparam int OUT_W  = LANES * SUM_W
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [IN_W-1:0]   s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  input  logic              op_sub,
  output logic [OUT_W-1:0]  m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              frame_err,
  output logic [FCNT_W-1:0] frame_cnt
);
  localparam int BEATS = beats(ROWS, COLS, LANES);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  if (((ROWS * COLS) % LANES) != 0) begin : g_bad_lanes
    $error("ROWS*COLS must be a multiple of LANES");
  end

  logic             rst_q;
  logic [CNT_W-1:0] cnt;
  logic             op_lat;
  logic             v1;
  logic             op1;
  logic             last1;
  logic [IN_W-1:0]  d1;
  logic             v2;
  logic             last2;
  logic [OUT_W-1:0] res;
  logic [OUT_W-1:0] res_nxt;
  logic             adv1;
  logic             adv2;
  logic             in_hs;
  logic             at_last;
  logic             op_now;
  logic             last_in;

  // Async assert, release on the next clock edge; everything else resets from rst_q.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) rst_q <= 1'b0;
    else          rst_q <= 1'b1;
  end

  assign adv2          = !v2 || m_axis_tready;
  assign adv1          = !v1 || adv2;
  assign s_axis_tready = rst_q && adv1;
  assign in_hs         = s_axis_tvalid && s_axis_tready;
  assign at_last       = (cnt == LAST_CNT);
  assign op_now        = (cnt == '0) ? op_sub : op_lat;
  // An early sender tlast closes the frame here and resyncs the counter.
  assign last_in       = at_last || s_axis_tlast;

  always_ff @(posedge aclk or negedge rst_q) begin
    if (!rst_q) begin
      cnt       <= '0;
      op_lat    <= OP_ADD;
      frame_err <= 1'b0;
    end else if (in_hs) begin
      cnt <= last_in ? '0 : cnt + CNT_W'(1);
      if (cnt == '0) op_lat <= op_sub;
      if (s_axis_tlast != at_last) frame_err <= 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge rst_q) begin
    if (!rst_q) begin
      v1    <= 1'b0;
      d1    <= '0;
      op1   <= OP_ADD;
      last1 <= 1'b0;
    end else if (adv1) begin
      v1 <= in_hs;
      if (in_hs) begin
        d1    <= s_axis_tdata;
        op1   <= op_now;
        last1 <= last_in;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    matadd_lane_alu #(
      .DATA_W(DATA_W),
      .SUM_W (SUM_W)
    ) u_alu (
      .a (d1[a_lsb(i, DATA_W) +: DATA_W]),
      .b (d1[b_lsb(i, LANES, DATA_W) +: DATA_W]),
      .op(op1),
      .y (res_nxt[i*SUM_W +: SUM_W])
    );
  end

  always_ff @(posedge aclk or negedge rst_q) begin
    if (!rst_q) begin
      v2    <= 1'b0;
      res   <= '0;
      last2 <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        res   <= res_nxt;
        last2 <= last1;
      end
    end
  end

  always_ff @(posedge aclk or negedge rst_q) begin
    if (!rst_q) frame_cnt <= '0;
    else if (v2 && m_axis_tready && last2) frame_cnt <= frame_cnt + FCNT_W'(1);
  end

  assign m_axis_tvalid = v2;
  assign m_axis_tdata  = res;
  assign m_axis_tlast  = last2;

endmodule
